// File: rtl/usb_tx_arbiter.sv
// Purpose : shares one USB coder TX path between N packet sources, one packet per grant.
// Latency : grant/ack registered 1 clk after a request is seen in IDLE; data mux is combinational.
// Backpressure: new requests wait until the in-flight packet and its gap finish; the coder paces bytes via cd_rdreq.
//
// Ports:
//   clk, n_rst                      FCLK_OUT domain clock, async active-low reset
//   src_tx_rdy/src_tx_ack           per-source packet pending level / accept pulse
//   src_d/src_last_byte/src_rdreq   per-source byte stream and byte-advance strobe
//   cd_tx_rdy/cd_d/cd_last_byte     muxed packet stream towards the coder
//   cd_rdreq/cd_pck_sent            coder byte-consume strobe and packet-complete pulse
//   grant/busy/timeout_err          status: one-hot owner, in-flight flag, watchdog abort pulse
module usb_tx_arbiter #(
    parameter int N          = 2,
    parameter int PRIO_MODE  = 0,
    parameter int GAP_CYCLES = 4,
    parameter int TIMEOUT    = 65535
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [N-1:0]     src_tx_rdy,
    output logic [N-1:0]     src_tx_ack,
    input  logic [8*N-1:0]   src_d,
    input  logic [N-1:0]     src_last_byte,
    output logic [N-1:0]     src_rdreq,
    output logic             cd_tx_rdy,
    output logic [7:0]       cd_d,
    output logic             cd_last_byte,
    input  logic             cd_rdreq,
    input  logic             cd_pck_sent,
    output logic [N-1:0]     grant,
    output logic             busy,
    output logic             timeout_err
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ACK, S_BUSY, S_GAP} state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [N-1:0]    ack_q, ack_d;
    logic            cd_rdy_q, cd_rdy_d;
    logic            busy_q, busy_d;
    logic            to_q, to_d;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic [GW-1:0]   gap_q, gap_d;
    // Round-robin search start index: one past the last winner (0 after reset).
    logic [PW-1:0]   ptr_q, ptr_d;

    logic [PW-1:0]   win_idx;
    logic [PW-1:0]   nxt_ptr;
    logic            found;

    // Arbitration: pick the winning index among pending sources.
    always_comb begin
        win_idx = '0;
        found   = 1'b0;
        if (PRIO_MODE == 1) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (src_tx_rdy[i]) begin
                    win_idx = PW'(i);
                    found   = 1'b1;
                end
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                if (!found && src_tx_rdy[(int'(ptr_q) + k) % N]) begin
                    win_idx = PW'((int'(ptr_q) + k) % N);
                    found   = 1'b1;
                end
            end
        end
    end

    // Data path muxes driven from the registered grant.
    always_comb begin
        cd_d    = '0;
        nxt_ptr = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_q[i]) begin
                cd_d    = src_d[8*i +: 8];
                nxt_ptr = PW'((i + 1) % N);
            end
        end
    end

    assign cd_last_byte = (state_q == S_BUSY) & (|(src_last_byte & grant_q));
    assign src_rdreq    = {N{cd_rdreq & (state_q == S_BUSY)}} & grant_q;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        ack_d    = '0;
        cd_rdy_d = cd_rdy_q;
        busy_d   = busy_q;
        to_d     = 1'b0;
        tmr_d    = tmr_q;
        gap_d    = gap_q;
        ptr_d    = ptr_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d          = S_ACK;
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    ack_d            = '0;
                    ack_d[win_idx]   = 1'b1;
                    cd_rdy_d         = 1'b1;
                    busy_d           = 1'b1;
                end
            end
            S_ACK: begin
                state_d = S_BUSY;
                tmr_d   = '0;
                ptr_d   = nxt_ptr;
            end
            S_BUSY: begin
                // pck_sent takes precedence over a coincident watchdog expiry.
                if (cd_pck_sent || (tmr_q == TW'(TIMEOUT - 1))) begin
                    to_d     = ~cd_pck_sent;
                    cd_rdy_d = 1'b0;
                    gap_d    = '0;
                    if (GAP_CYCLES == 0) begin
                        state_d = S_IDLE;
                        grant_d = '0;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = S_GAP;
                    end
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            S_GAP: begin
                if (gap_q == GW'(GAP_CYCLES - 1)) begin
                    state_d = S_IDLE;
                    grant_d = '0;
                    busy_d  = 1'b0;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= S_IDLE;
            grant_q  <= '0;
            ack_q    <= '0;
            cd_rdy_q <= 1'b0;
            busy_q   <= 1'b0;
            to_q     <= 1'b0;
            tmr_q    <= '0;
            gap_q    <= '0;
            ptr_q    <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            ack_q    <= ack_d;
            cd_rdy_q <= cd_rdy_d;
            busy_q   <= busy_d;
            to_q     <= to_d;
            tmr_q    <= tmr_d;
            gap_q    <= gap_d;
            ptr_q    <= ptr_d;
        end
    end

    assign grant       = grant_q;
    assign src_tx_ack  = ack_q;
    assign cd_tx_rdy   = cd_rdy_q;
    assign busy        = busy_q;
    assign timeout_err = to_q;
endmodule
